// File: rtl/multiport_latency_mem.sv
// multiport_latency_mem: NUM_PORTS request FIFOs, round-robin arbiter, one fixed-latency byte-memory engine, drain handshake
module multiport_latency_mem #(
    parameter int    NUM_PORTS  = 2,
    parameter int    ADDR_WIDTH = 20,
    parameter int    MEM_SIZE   = 1 << 20,
    parameter int    LINE_BYTES = 16,
    parameter int    LATENCY    = 4,
    parameter int    FIFO_DEPTH = 4,
    parameter string INIT_FILE  = ""
) (
    input  logic                               clk_i,
    input  logic                               rst_i,
    input  logic [NUM_PORTS-1:0]               req_valid_i,
    output logic [NUM_PORTS-1:0]               req_ready_o,
    input  logic [NUM_PORTS-1:0]               req_we_i,
    input  logic [2*NUM_PORTS-1:0]             req_size_i,
    input  logic [NUM_PORTS*ADDR_WIDTH-1:0]    req_addr_i,
    input  logic [NUM_PORTS*LINE_BYTES*8-1:0]  req_wdata_i,
    output logic [NUM_PORTS-1:0]               resp_valid_o,
    output logic                               resp_is_write_o,
    output logic [LINE_BYTES*8-1:0]            resp_data_o,
    input  logic                               finish_i,
    output logic                               done_o,
    input  logic [ADDR_WIDTH-1:0]              dbg_addr_i,
    output logic [7:0]                         dbg_data_o
);
    localparam int DW = LINE_BYTES * 8;
    localparam int MW = $clog2(MEM_SIZE);
    localparam int FW = $clog2(FIFO_DEPTH);
    localparam int CW = FW + 1;
    localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam int TW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
    logic [7:0]            mem_q [MEM_SIZE];
    logic                  f_we_q    [NUM_PORTS][FIFO_DEPTH];
    logic [1:0]            f_size_q  [NUM_PORTS][FIFO_DEPTH];
    logic [ADDR_WIDTH-1:0] f_addr_q  [NUM_PORTS][FIFO_DEPTH];
    logic [DW-1:0]         f_wdata_q [NUM_PORTS][FIFO_DEPTH];
    logic [FW-1:0]         wp_q [NUM_PORTS];
    logic [FW-1:0]         rp_q [NUM_PORTS];
    logic [CW-1:0]         cnt_q [NUM_PORTS];
    logic [NUM_PORTS-1:0]  push, pop, empty;
    state_t                state_q, state_d;
    logic [PW-1:0]         rr_q, port_q, gnt_p;
    logic                  gnt_v, grant, commit;
    logic [TW-1:0]         tmr_q;
    logic                  cur_we_q;
    logic [1:0]            cur_size_q;
    logic [ADDR_WIDTH-1:0] cur_addr_q;
    logic [DW-1:0]         cur_wdata_q, rdata_q, rd;
    logic [MW-1:0]         base;
    int                    nb;
    logic                  drain_q, done_q;
    logic                  unused_ok;
    assign unused_ok = ^{dbg_addr_i, cur_addr_q};
    always_comb begin
        for (int p = 0; p < NUM_PORTS; p++) begin
            empty[p] = cnt_q[p] == '0;
            req_ready_o[p] = (cnt_q[p] != CW'(FIFO_DEPTH)) && !drain_q;
            push[p] = req_valid_i[p] && req_ready_o[p];
            pop[p] = grant && gnt_p == PW'(p);
        end
    end
    always_comb begin
        gnt_v = 1'b0;
        gnt_p = '0;
        for (int p = NUM_PORTS - 1; p >= 0; p--)
            if (!empty[p] && PW'(p) <= rr_q) begin
                gnt_v = 1'b1;
                gnt_p = PW'(p);
            end
        for (int p = NUM_PORTS - 1; p >= 0; p--)
            if (!empty[p] && PW'(p) > rr_q) begin
                gnt_v = 1'b1;
                gnt_p = PW'(p);
            end
    end
    assign grant  = gnt_v && state_q != BUSY;
    assign commit = state_q == BUSY && tmr_q == '0;
    always_ff @(posedge clk_i) begin
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (rst_i) begin
                wp_q[p]  <= '0;
                rp_q[p]  <= '0;
                cnt_q[p] <= '0;
            end else begin
                if (push[p]) begin
                    f_we_q[p][wp_q[p]]    <= req_we_i[p];
                    f_size_q[p][wp_q[p]]  <= req_size_i[2*p +: 2];
                    f_addr_q[p][wp_q[p]]  <= req_addr_i[ADDR_WIDTH*p +: ADDR_WIDTH];
                    f_wdata_q[p][wp_q[p]] <= req_wdata_i[DW*p +: DW];
                    wp_q[p] <= wp_q[p] + 1'b1;
                end
                if (pop[p])
                    rp_q[p] <= rp_q[p] + 1'b1;
                cnt_q[p] <= cnt_q[p] + CW'(push[p]) - CW'(pop[p]);
            end
        end
    end
    always_ff @(posedge clk_i) begin
        if (rst_i)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end
    always_comb state_d = (state_q == BUSY) ? ((tmr_q == '0) ? RESP : BUSY) : (grant ? BUSY : IDLE);
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rr_q    <= PW'(NUM_PORTS - 1);
            port_q  <= '0;
            tmr_q   <= '0;
            rdata_q <= '0;
            drain_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            if (grant) begin
                rr_q        <= gnt_p;
                port_q      <= gnt_p;
                cur_we_q    <= f_we_q[gnt_p][rp_q[gnt_p]];
                cur_size_q  <= f_size_q[gnt_p][rp_q[gnt_p]];
                cur_addr_q  <= f_addr_q[gnt_p][rp_q[gnt_p]];
                cur_wdata_q <= f_wdata_q[gnt_p][rp_q[gnt_p]];
                tmr_q       <= TW'(LATENCY - 1);
            end else if (state_q == BUSY && tmr_q != '0)
                tmr_q <= tmr_q - 1'b1;
            if (commit)
                rdata_q <= cur_we_q ? '0 : rd;
            drain_q <= drain_q | finish_i;
            done_q  <= done_o;
        end
    end
    always_comb begin
        nb = (cur_size_q == 2'd3) ? LINE_BYTES : (1 << cur_size_q);
        base = (cur_size_q == 2'd3) ? (cur_addr_q[MW-1:0] & ~MW'(LINE_BYTES - 1)) : cur_addr_q[MW-1:0];
        for (int i = 0; i < LINE_BYTES; i++)
            rd[8*i +: 8] = (i < nb) ? mem_q[base + MW'(i)] : 8'h00;
    end
    always_ff @(posedge clk_i) begin
        if (!rst_i && commit && cur_we_q)
            for (int i = 0; i < LINE_BYTES; i++)
                if (i < nb)
                    mem_q[base + MW'(i)] <= cur_wdata_q[8*i +: 8];
    end
    always_comb begin
        resp_valid_o    = (state_q == RESP) ? (NUM_PORTS'(1) << port_q) : '0;
        resp_is_write_o = state_q == RESP && cur_we_q;
        resp_data_o     = (state_q == RESP) ? rdata_q : '0;
        done_o          = done_q || (drain_q && &empty && state_q == IDLE);
        dbg_data_o      = mem_q[dbg_addr_i[MW-1:0]];
    end
endmodule

// File: tb/tb_multiport_latency_mem.sv
// tb_multiport_latency_mem: directed and random traffic against a byte-array reference with per-port in-order scoreboards
module tb_multiport_latency_mem;
    localparam int NP = 2, AW = 20, MS = 1024, LB = 16, LAT = 4, FD = 4, DW = 128;
    typedef struct packed {
        logic          we;
        logic [1:0]    size;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
    } req_t;
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic              rst, resp_is_write, finish, done;
    logic [NP-1:0]     req_valid, req_ready, req_we, resp_valid;
    logic [2*NP-1:0]   req_size;
    logic [NP*AW-1:0]  req_addr;
    logic [NP*DW-1:0]  req_wdata;
    logic [DW-1:0]     resp_data;
    logic [AW-1:0]     dbg_addr;
    logic [7:0]        dbg_data;
    multiport_latency_mem #(
        .NUM_PORTS(NP), .ADDR_WIDTH(AW), .MEM_SIZE(MS), .LINE_BYTES(LB),
        .LATENCY(LAT), .FIFO_DEPTH(FD), .INIT_FILE("")
    ) dut (
        .clk_i(clk), .rst_i(rst), .req_valid_i(req_valid), .req_ready_o(req_ready),
        .req_we_i(req_we), .req_size_i(req_size), .req_addr_i(req_addr), .req_wdata_i(req_wdata),
        .resp_valid_o(resp_valid), .resp_is_write_o(resp_is_write), .resp_data_o(resp_data),
        .finish_i(finish), .done_o(done), .dbg_addr_i(dbg_addr), .dbg_data_o(dbg_data)
    );
    int          checks = 0, failures = 0;
    logic [7:0]  ref_mem [MS];
    req_t        q0[$], q1[$];
    int          ports[$];
    logic [DW-1:0] last_rd;
    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask
    task automatic model_op(input req_t r, output logic [DW-1:0] d);
        int n, b, idx;
        n = (r.size == 2'd3) ? LB : (1 << r.size);
        b = (r.size == 2'd3) ? int'(r.addr) / LB * LB : int'(r.addr);
        d = '0;
        for (int i = 0; i < n; i++) begin
            idx = (b + i) % MS;
            if (r.we) ref_mem[idx] = r.wdata[8*i +: 8];
            else d[8*i +: 8] = ref_mem[idx];
        end
    endtask
    function automatic req_t mk(input logic we, input logic [1:0] sz, input logic [AW-1:0] a, input logic [DW-1:0] wd);
        req_t r;
        r.we = we; r.size = sz; r.addr = a; r.wdata = wd;
        return r;
    endfunction
    function automatic req_t gen();
        req_t r;
        r.we = 1'($urandom_range(1));
        r.size = 2'($urandom_range(3));
        r.addr = ($urandom_range(3) == 0) ? AW'(1024 * $urandom_range(1023) + $urandom_range(1023, 1003)) : AW'($urandom);
        r.wdata = {$urandom, $urandom, $urandom, $urandom};
        return r;
    endfunction
    task automatic tick();
        req_t r;
        logic [DW-1:0] d;
        int p;
        @(posedge clk);
        #1;
        if (resp_valid !== 2'b00) begin
            chk("resp_onehot", resp_valid == 2'b11, 0);
            p = resp_valid[1] ? 1 : 0;
            if ((p == 0 && q0.size() == 0) || (p == 1 && q1.size() == 0))
                chk("resp_spurious", resp_valid, 0);
            else begin
                if (p == 0) r = q0.pop_front();
                else r = q1.pop_front();
                model_op(r, d);
                chk("resp_data", resp_data, d);
                chk("resp_is_write", resp_is_write, r.we);
                ports.push_back(p);
                if (!r.we) last_rd = resp_data;
            end
        end
    endtask
    task automatic drive(input int p, input req_t r);
        req_we[p] = r.we;
        req_size[2*p +: 2] = r.size;
        req_addr[AW*p +: AW] = r.addr;
        req_wdata[DW*p +: DW] = r.wdata;
        req_valid[p] = 1'b1;
    endtask
    task automatic push(input int p, input req_t r);
        if (p == 0) q0.push_back(r);
        else q1.push_back(r);
    endtask
    task automatic send(input int p, input req_t r);
        drive(p, r);
        for (int t = 0; t < 100 && !req_ready[p]; t++) tick();
        chk("send_ready", req_ready[p], 1);
        if (req_ready[p]) push(p, r);
        tick();
        req_valid[p] = 1'b0;
    endtask
    task automatic rand_cycle(input int pct);
        req_t r;
        for (int p = 0; p < NP; p++)
            if ($urandom_range(99) < pct) begin
                r = gen();
                drive(p, r);
                if (req_ready[p]) push(p, r);
            end
        tick();
        req_valid = '0;
    endtask
    task automatic drain();
        for (int t = 0; t < 3000 && (q0.size() + q1.size()) != 0; t++) tick();
        chk("drain_timeout", q0.size() + q1.size(), 0);
        tick();
    endtask
    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        q0.delete();
        q1.delete();
    endtask
    initial begin
        int n0;
        rst = 1'b1; finish = 1'b0; req_valid = '0; req_we = '0; req_size = '0;
        req_addr = '0; req_wdata = '0; dbg_addr = '0; last_rd = '0;
        do_reset();
        chk("rst_resp_valid", resp_valid, 0);
        chk("rst_resp_data", resp_data, 0);
        chk("rst_is_write", resp_is_write, 0);
        chk("rst_done", done, 0);
        chk("rst_ready", req_ready, 2'b11);
        for (int l = 0; l < MS / LB; l++)
            send(l % 2, mk(1'b1, 2'd3, AW'(l * LB), {$urandom, $urandom, $urandom, $urandom}));
        drain();
        send(0, mk(1'b1, 2'd2, 20'h01000, 128'h93));
        drain();
        send(0, mk(1'b0, 2'd2, 20'h01000, 128'h0));
        for (int k = 0; k < LAT; k++) begin
            tick();
            chk("lat_quiet", resp_valid, 0);
        end
        tick();
        chk("lat_resp", resp_valid, 2'b01);
        chk("lat_data", resp_data, 128'h93);
        drain();
        send(0, mk(1'b1, 2'd2, 20'h00020, 128'h0));
        send(1, mk(1'b1, 2'd0, 20'h00020, 128'hAB));
        send(0, mk(1'b0, 2'd2, 20'h00020, 128'h0));
        drain();
        chk("sb_lw_data", last_rd, 128'hAB);
        dbg_addr = 20'h00020;
        #1;
        chk("sb_dbg", dbg_data, 8'hAB);
        ports.delete();
        send(1, mk(1'b0, 2'd3, 20'h00000, 128'h0));
        for (int k = 0; k < FD; k++) send(0, gen());
        chk("fifo_full_ready", req_ready[0], 0);
        send(0, gen());
        drain();
        n0 = 0;
        foreach (ports[i]) if (ports[i] == 0) n0++;
        chk("fifo_p0_count", n0, 5);
        do_reset();
        ports.delete();
        repeat (3) rand_cycle(100);
        drain();
        chk("arb_len", ports.size(), 6);
        for (int i = 0; i < 6 && i < ports.size(); i++) chk("arb_order", ports[i], i % 2);
        send(0, mk(1'b1, 2'd2, 20'h00040, 128'hDEADBEEF));
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        q0.delete();
        q1.delete();
        chk("midrst_ready", req_ready, 2'b11);
        chk("midrst_done", done, 0);
        chk("midrst_resp", resp_valid, 0);
        repeat (2 * LAT) begin
            tick();
            chk("midrst_noresp", resp_valid, 0);
        end
        for (int i = 0; i < 4; i++) begin
            dbg_addr = AW'(20'h40 + i);
            #1;
            chk("midrst_mem", dbg_data, ref_mem[20'h40 + i]);
        end
        repeat (400) rand_cycle(50);
        drain();
        repeat (16) begin
            dbg_addr = AW'($urandom);
            #1;
            chk("dbg_rand", dbg_data, ref_mem[int'(dbg_addr) % MS]);
        end
        chk("pre_finish_done", done, 0);
        for (int k = 0; k < 3; k++) send(0, mk(1'b0, 2'($urandom_range(3)), AW'($urandom), 128'h0));
        finish = 1'b1;
        tick();
        finish = 1'b0;
        chk("drain_ready", req_ready, 2'b00);
        drive(1, gen());
        for (int t = 0; t < 100 && q0.size() != 0; t++) begin
            tick();
            chk("done_early", done, 0);
        end
        chk("drain_resp_left", q0.size(), 0);
        tick();
        chk("done_rise", done, 1);
        req_valid = '0;
        finish = 1'b1;
        tick();
        finish = 1'b0;
        repeat (3) tick();
        chk("done_sticky", done, 1);
        chk("done_ready", req_ready, 2'b00);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
